fetch_stage: RTL and testbench

Instruction fetch front-end that sits directly upstream of the byte-addressed instruction memory and downstream of execute's redirect path. It owns the program counter and drives the instruction-memory address. It captures the combinationally returned word into a small in-order fetch queue, and presents {instr, pc, pc+4} to decode with a valid/ready handshake. Branch/jump redirects flush the queue and retarget the PC.

---
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front-end: owns the PC, drives instruction memory and buffers fetched words in an in-order queue.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'hBFC00000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_stall_cnt_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_q;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      q_instr [FIFO_DEPTH];
    logic [31:0]      q_pc    [FIFO_DEPTH];
    logic             push;
    logic             pop;

    assign imem_addr_o = pc_q;
    assign valid_o     = (count != '0);
    assign pop         = valid_o & ready_i;
    // A full queue still accepts a new word when the head leaves in the same cycle.
    assign push        = !redirect_i && ((count < DEPTH_C) || pop);

    assign instr_o    = valid_o ? q_instr[rd_ptr]          : '0;
    assign pc_o       = valid_o ? q_pc[rd_ptr]             : '0;
    assign pc_plus4_o = valid_o ? (q_pc[rd_ptr] + 32'd4)   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            pc_q   <= {redirect_pc_i[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                pc_q   <= pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: entries are only observable while count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_instr_i;
            q_pc[wr_ptr]    <= pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (valid_o && !ready_i && !redirect_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`else
    assign perf_fetch_cnt_o = '0;
    assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by randomized traffic against a queue-based model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC   = 32'hBFC00000;
    localparam int unsigned FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] m_pc      = RESET_PC;
    logic [31:0] m_fetch   = '0;
    logic [31:0] m_stall   = '0;
    bit          m_valid   = 1'b0;
    bit          armed     = 1'b0;

    fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr_o      (imem_addr_o),
        .imem_instr_i     (imem_instr_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o),
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    assign imem_instr_i = mem_word(imem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched words and a PC, advanced from the rules on each clock.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_pc    = RESET_PC;
            m_fetch = '0;
            m_stall = '0;
            armed   = 1'b1;
        end else if (redirect_i) begin
            exp_q.delete();
            m_pc = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (m_valid && !ready_i) m_stall = m_stall + 32'd1;
            if (exp_q.size() < FIFO_DEPTH) begin
                exp_q.push_back('{instr: mem_word(m_pc), pc: m_pc});
                m_pc    = m_pc + 32'd4;
                m_fetch = m_fetch + 32'd1;
            end
        end
    end

    // Monitor: compares the presented head with the scoreboard and retires it on a handshake.
    always @(negedge clk) begin
        if (armed) begin
            m_valid = (exp_q.size() != 0);
            chk("imem_addr", imem_addr_o, m_pc);
            chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
            if (m_valid && valid_o) begin
                chk("instr", instr_o, exp_q[0].instr);
                chk("pc", pc_o, exp_q[0].pc);
                chk("pc_plus4", pc_plus4_o, exp_q[0].pc + 32'd4);
            end else if (!m_valid) begin
                chk("instr_empty", instr_o, 32'h0);
                chk("pc_empty", pc_o, 32'h0);
                chk("pc_plus4_empty", pc_plus4_o, 32'h0);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch", perf_fetch_cnt_o, m_fetch);
            chk("perf_stall", perf_stall_cnt_o, m_stall);
`else
            chk("perf_fetch_off", perf_fetch_cnt_o, 32'h0);
            chk("perf_stall_off", perf_stall_cnt_o, 32'h0);
`endif
            if (m_valid && ready_i && !redirect_i && !rst && exp_q.size() != 0)
                void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        rst           = r;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        ready_i       = rdy;
    endtask

    int thr;

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        tick();

        // Streaming after reset
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("d1_valid0", {31'd0, valid_o}, 32'd0);
        chk("d1_addr0", imem_addr_o, 32'hBFC00000);
        tick();
        chk("d1_valid1", {31'd0, valid_o}, 32'd1);
        chk("d1_pc1", pc_o, 32'hBFC00000);
        chk("d1_instr1", instr_o, 32'h00500093);
        chk("d1_pc4_1", pc_plus4_o, 32'hBFC00004);
        tick();
        chk("d1_pc2", pc_o, 32'hBFC00004);
        tick();
        chk("d1_pc3", pc_o, 32'hBFC00008);

        // Backpressure from reset, then release
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (4) tick();
        chk("d2_addr_frozen", imem_addr_o, 32'hBFC00008);
        chk("d2_head_pc", pc_o, 32'hBFC00000);
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        chk("d2_pc_a", pc_o, 32'hBFC00004);
        chk("d2_addr_adv", imem_addr_o, 32'hBFC0000C);
        tick();
        chk("d2_pc_b", pc_o, 32'hBFC00008);
        tick();
        chk("d2_pc_c", pc_o, 32'hBFC0000C);
`ifdef FETCH_PERF_CNT_EN
        chk("d2_perf_fetch", perf_fetch_cnt_o, 32'd5);
        chk("d2_perf_stall", perf_stall_cnt_o, 32'd3);
`else
        chk("d2_perf_fetch", perf_fetch_cnt_o, 32'd0);
        chk("d2_perf_stall", perf_stall_cnt_o, 32'd0);
`endif

        // Redirect while the queue is full
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'hBFC00103, 1'b0);
        chk("d3_valid_n", {31'd0, valid_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("d3_valid_n1", {31'd0, valid_o}, 32'd0);
        chk("d3_addr_n1", imem_addr_o, 32'hBFC00100);
        tick();
        chk("d3_valid_n2", {31'd0, valid_o}, 32'd1);
        chk("d3_pc_n2", pc_o, 32'hBFC00100);

        // Reset together with a redirect
        repeat (3) tick();
        drive(1'b1, 1'b1, 32'h12345678, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("d4_addr", imem_addr_o, 32'hBFC00000);
        chk("d4_valid", {31'd0, valid_o}, 32'd0);
        chk("d4_perf_fetch", perf_fetch_cnt_o, 32'd0);
        chk("d4_perf_stall", perf_stall_cnt_o, 32'd0);

        // Randomized traffic
        thr = 7;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            if (i % 100 == 0) thr = $urandom_range(1, 10);
            if ($urandom_range(0, 3) == 0)
                rpc = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else
                rpc = 32'hBFC00000 + 32'($urandom_range(0, 4095));
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 11) == 0),
                  rpc,
                  ($urandom_range(0, 9) < thr));
            tick();
        end

        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
